// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor types and constants for the data-memory dump path
package proc_pkg;

  localparam int DATA_W     = 64;
  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    OUT,
    DONE
  } dump_state_t;

endpackage

// File: rtl/dmem_dump_arbiter.sv
// rtl/dmem_dump_arbiter.sv - shares data memory between the CPU and a word-streaming dump engine
module dmem_dump_arbiter
  import proc_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         dump,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_wdata,
  input  logic         cpu_we,
  output logic         cpu_stall,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_done
);

  dump_state_t      state;
  logic [IDX_W-1:0] idx;
  logic             dump_q;
  logic             start;
  logic             last_word;
  logic [N-1:0]     idx_addr;

  assign start     = dump & ~dump_q;
  assign last_word = (idx == IDX_W'(DEPTH - 1));
  assign idx_addr  = N'(idx) * N'(WORD_BYTES);

  // Status outputs are registered alongside the state so they change only on state transitions.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      dump_q     <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
      cpu_stall  <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      dump_q <= dump;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            idx       <= '0;
            cpu_stall <= 1'b1;
          end
        end
        READ: begin
          dump_data  <= mem_rdata;
          dump_addr  <= idx_addr;
          dump_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (last_word) begin
              dump_done <= 1'b1;
              state     <= DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= READ;
            end
          end
        end
        DONE: begin
          if (!dump) begin
            dump_done <= 1'b0;
            cpu_stall <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          cpu_stall  <= 1'b0;
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

  // Outside IDLE the dump engine owns the address and stores are blocked outright.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we;
    if (state != IDLE) begin
      mem_addr = idx_addr;
      mem_we   = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// tb/tb_dmem_dump_arbiter.sv - randomized self-checking bench for dmem_dump_arbiter
module tb_dmem_dump_arbiter;

  localparam int N     = 64;
  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         dump;
  logic [N-1:0] cpu_addr;
  logic [N-1:0] cpu_wdata;
  logic         cpu_we;
  logic         cpu_stall;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;
  logic [N-1:0] mem_rdata;
  logic         dump_valid;
  logic         dump_ready;
  logic [N-1:0] dump_addr;
  logic [N-1:0] dump_data;
  logic         dump_done;

  logic [N-1:0] mem     [DEPTH];
  logic [N-1:0] ref_mem [DEPTH];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_dump_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .dump      (dump),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_done (dump_done)
  );

  assign mem_rdata = mem[mem_addr[IDX_W+2:3]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[IDX_W+2:3]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_store(input logic [N-1:0] a, input logic [N-1:0] d);
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    check("pass_we", mem_we, 1'b1);
    check("pass_addr", mem_addr, a);
    check("pass_wdata", mem_wdata, d);
    check("pass_stall", cpu_stall, 1'b0);
    ref_mem[a[IDX_W+2:3]] = d;
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  // Expected stream: every word in address order, as memory stood at the start edge.
  task automatic do_dump(input bit rnd_ready, input int bp_word, input int drop_at, input bit collide);
    logic [N-1:0] exp_q [DEPTH];
    int k, cycles, bp_left;
    @(posedge clk); #1;
    dump = 1'b1;
    dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (collide) begin
      cpu_we = 1'b1; cpu_addr = 64'h20; cpu_wdata = 64'h55;
      ref_mem[4] = 64'h55;
    end else begin
      cpu_we = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) exp_q[i] = ref_mem[i];
    @(negedge clk);
    check("edge_stall", cpu_stall, 1'b0);
    check("edge_we", mem_we, collide);
    k = 0; cycles = 0; bp_left = 5;
    while (k < DEPTH && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 64'($urandom_range(0, DEPTH - 1)) * 8;
      cpu_wdata = {$urandom, $urandom};
      if (drop_at >= 0 && k >= drop_at) dump = 1'b0;
      if (k == bp_word && bp_left > 0) dump_ready = 1'b0;
      else dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      check("dump_mem_we", mem_we, 1'b0);
      if (cycles == 1) begin
        check("stall_edge1", cpu_stall, 1'b1);
        check("valid_edge1", dump_valid, 1'b0);
      end
      if (cycles == 2) check("valid_edge2", dump_valid, 1'b1);
      if (dump_valid) begin
        check("dump_addr", dump_addr, 64'(k) * 8);
        check("dump_data", dump_data, exp_q[k]);
        if (dump_ready) k++;
        else if (k == bp_word) bp_left--;
      end
    end
    if (k < DEPTH) check("dump_timeout", 1'b0, 1'b1);
    if (!rnd_ready && bp_word < 0) check("dump_cycles", 64'(cycles), 64'(2 * DEPTH));
    if (bp_word >= 0) check("bp_cycles_held", 64'(bp_left), 64'd0);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    dump_ready = 1'b0;
    @(negedge clk);
    check("done_flag", dump_done, 1'b1);
    check("done_valid", dump_valid, 1'b0);
    check("done_stall", cpu_stall, 1'b1);
    if (!dump) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("drop_exit_stall", cpu_stall, 1'b0);
      check("drop_exit_done", dump_done, 1'b0);
    end
  endtask

  task automatic release_dump();
    @(posedge clk); #1;
    dump = 1'b0;
    @(negedge clk);
    check("rel_still_stall", cpu_stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rel_stall", cpu_stall, 1'b0);
    check("rel_done", dump_done, 1'b0);
  endtask

  initial begin
    int guard;
    reset = 1'b1; dump = 1'b0; dump_ready = 1'b0;
    cpu_we = 1'b0; cpu_addr = 64'h40; cpu_wdata = 64'h1234;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 64'(i) + 64'h100;
      ref_mem[i] = 64'(i) + 64'h100;
    end
    repeat (2) @(negedge clk);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_valid", dump_valid, 1'b0);
    check("rst_done", dump_done, 1'b0);
    check("rst_daddr", dump_addr, 64'h0);
    check("rst_ddata", dump_data, 64'h0);
    check("rst_maddr", mem_addr, 64'h40);
    check("rst_mwe", mem_we, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    cpu_store(64'h10, 64'hDEADBEEF);
    cpu_store(64'h10, 64'h102);

    do_dump(1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_done", dump_done, 1'b1);
      check("hold_no_retrig", dump_valid, 1'b0);
    end
    release_dump();

    do_dump(1'b0, 3, -1, 1'b1);
    release_dump();

    for (int i = 0; i < 20; i++)
      cpu_store(64'($urandom_range(0, DEPTH - 1)) * 8, {$urandom, $urandom});

    do_dump(1'b1, -1, 20, 1'b0);
    do_dump(1'b1, -1, -1, 1'b0);
    release_dump();

    for (int i = 0; i < DEPTH; i++) check("mem_intact", mem[i], ref_mem[i]);

    // Reset in the middle of a walk, while word 10 is on offer.
    @(posedge clk); #1;
    dump = 1'b1; dump_ready = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(dump_valid && dump_addr == 64'h50) && guard < 500);
    check("reach_word10", dump_addr, 64'h50);
    reset = 1'b1; dump = 1'b0; cpu_addr = 64'h30;
    #1;
    check("arst_valid", dump_valid, 1'b0);
    check("arst_stall", cpu_stall, 1'b0);
    check("arst_maddr", mem_addr, 64'h30);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_store(64'h30, 64'hCAFE);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_store", mem[6], 64'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
